// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the program counter, drives the SPI flash
// reader handshake, reorders the returned word into RV32 little-endian form
// and hands one instruction at a time to the decoder. It also handles
// branch/jump redirects and retries a fetch that never completes.
module instr_fetch #(
  parameter logic [23:0] RESET_PC = 24'h000000,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_load,
  input  logic [23:0] pc_load_addr,
  output logic [23:0] mem_address,
  output logic        mem_start_fetch,
  input  logic        mem_fetch_done,
  input  logic [31:0] mem_fetched_data,
  output logic [31:0] instr,
  output logic [23:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  // Count value on the last allowed FETCH cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  // The flash delivers the lowest-addressed byte in [31:24]; RV32 wants it in [7:0].
  function automatic logic [31:0] spi_to_le(input logic [31:0] d);
    spi_to_le = {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Redirect targets are always word aligned.
  function automatic logic [23:0] align_word(input logic [23:0] a);
    align_word = {a[23:2], 2'b00};
  endfunction

  state_t      state_q, state_d;
  logic [23:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] mem_address_q, mem_address_d;
  logic        mem_start_fetch_q, mem_start_fetch_d;
  logic [31:0] instr_q, instr_d;
  logic [23:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_timeout_q, fetch_timeout_d;

  // Next-state, PC and registered-output computation.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    cnt_d           = cnt_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    fetch_timeout_d = 1'b0;

    case (state_q)
      GAP: begin
        // Start is low here for one cycle so the reader returns to idle.
        state_d = FETCH;
        cnt_d   = '0;
        if (pc_load) begin
          pc_d = align_word(pc_load_addr);
        end
      end

      FETCH: begin
        cnt_d = cnt_q + 16'd1;
        if (pc_load) begin
          // Redirect wins over a same-cycle completion; that data is stale.
          pc_d    = align_word(pc_load_addr);
          state_d = GAP;
        end else if (mem_fetch_done) begin
          instr_d    = spi_to_le(mem_fetched_data);
          instr_pc_d = pc_q;
          state_d    = VALID;
        end else if (cnt_q == CNT_LAST) begin
          fetch_timeout_d = 1'b1;
          state_d         = GAP;
        end
      end

      VALID: begin
        // Start has been low at least one cycle, so FETCH may follow directly.
        if (instr_ready) begin
          pc_d    = pc_load ? align_word(pc_load_addr) : pc_q + 24'd4;
          cnt_d   = '0;
          state_d = FETCH;
        end else if (pc_load) begin
          pc_d    = align_word(pc_load_addr);
          cnt_d   = '0;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = GAP;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    mem_start_fetch_d = (state_d == FETCH);
    instr_valid_d     = (state_d == VALID);
    mem_address_d     = ((state_d == FETCH) && (state_q != FETCH)) ? pc_d : mem_address_q;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= GAP;
      pc_q              <= RESET_PC;
      cnt_q             <= '0;
      mem_address_q     <= RESET_PC;
      mem_start_fetch_q <= 1'b0;
      instr_q           <= '0;
      instr_pc_q        <= '0;
      instr_valid_q     <= 1'b0;
      fetch_timeout_q   <= 1'b0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      cnt_q             <= cnt_d;
      mem_address_q     <= mem_address_d;
      mem_start_fetch_q <= mem_start_fetch_d;
      instr_q           <= instr_d;
      instr_pc_q        <= instr_pc_d;
      instr_valid_q     <= instr_valid_d;
      fetch_timeout_q   <= fetch_timeout_d;
    end
  end

  assign mem_address     = mem_address_q;
  assign mem_start_fetch = mem_start_fetch_q;
  assign instr           = instr_q;
  assign instr_pc        = instr_pc_q;
  assign instr_valid     = instr_valid_q;
  assign fetch_timeout   = fetch_timeout_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then a
// randomized run, all compared every cycle against a transaction-level model.
module tb_instr_fetch;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        pc_load;
  logic [23:0] pc_load_addr;
  logic [23:0] mem_address;
  logic        mem_start_fetch;
  logic        mem_fetch_done;
  logic [31:0] mem_fetched_data;
  logic [31:0] instr;
  logic [23:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_timeout;

  instr_fetch #(.RESET_PC(24'h000000), .TIMEOUT(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_load          (pc_load),
    .pc_load_addr     (pc_load_addr),
    .mem_address      (mem_address),
    .mem_start_fetch  (mem_start_fetch),
    .mem_fetch_done   (mem_fetch_done),
    .mem_fetched_data (mem_fetched_data),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .fetch_timeout    (fetch_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit rand_mode = 1'b0;
  int mem_lat = 3;   // 0 means the flash never answers
  int mem_age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Flash contents: word 0 holds "addi x1,x0,1" in SPI byte order.
  function automatic logic [31:0] flash_word(input logic [23:0] a);
    if (a == 24'h0) return 32'h93001000;
    return {a[7:0] ^ 8'h5A, a[15:8], a[23:16] ^ 8'hC3, 8'h17};
  endfunction

  // ---------------- behavioural model ----------------
  localparam int PH_GAP = 0, PH_REQ = 1, PH_HOLD = 2;
  int          m_phase;
  int          m_age;
  logic [23:0] m_pc, m_addr, m_ipc;
  logic [31:0] m_instr;
  logic        m_start, m_valid, m_to;

  task automatic model_reset();
    m_phase = PH_GAP; m_age = 0; m_pc = 24'h0; m_addr = 24'h0; m_ipc = 24'h0;
    m_instr = 32'h0; m_start = 1'b0; m_valid = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step();
    logic [23:0] tgt;
    logic [31:0] sw;
    tgt = pc_load_addr & 24'hFFFFFC;
    m_to = 1'b0;
    if (m_phase == PH_GAP) begin
      if (pc_load) m_pc = tgt;
      m_phase = PH_REQ; m_age = 0; m_addr = m_pc; m_start = 1'b1;
    end else if (m_phase == PH_REQ) begin
      m_age++;
      if (pc_load) begin
        m_pc = tgt; m_phase = PH_GAP; m_start = 1'b0;
      end else if (mem_fetch_done) begin
        sw = {<<8{mem_fetched_data}};
        m_instr = sw; m_ipc = m_pc; m_valid = 1'b1; m_start = 1'b0; m_phase = PH_HOLD;
      end else if (m_age == TMO) begin
        m_to = 1'b1; m_start = 1'b0; m_phase = PH_GAP;
      end
    end else begin
      if (instr_ready || pc_load) begin
        m_pc = pc_load ? tgt : m_pc + 24'd4;
        m_valid = 1'b0; m_start = 1'b1; m_addr = m_pc; m_age = 0; m_phase = PH_REQ;
      end
    end
  endtask

  // Model advances on every active edge, or resets at once on rst.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare, then act as the flash, then (optionally) randomize decoder-side inputs.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("mem_address", {8'h0, mem_address}, {8'h0, m_addr});
        chk("mem_start_fetch", {31'h0, mem_start_fetch}, {31'h0, m_start});
        chk("instr", instr, m_instr);
        chk("instr_pc", {8'h0, instr_pc}, {8'h0, m_ipc});
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
        chk("fetch_timeout", {31'h0, fetch_timeout}, {31'h0, m_to});
      end
      mem_fetched_data = $urandom;
      mem_fetch_done   = 1'b0;
      if (mem_start_fetch === 1'b1) begin
        mem_age++;
        if (mem_lat != 0 && mem_age == mem_lat) begin
          mem_fetch_done   = 1'b1;
          mem_fetched_data = flash_word(mem_address);
        end
      end else begin
        mem_age = 0;
        if (rand_mode) mem_lat = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 5));
      end
      if (rand_mode) begin
        instr_ready  = ($urandom_range(0, 3) != 0);
        pc_load      = ($urandom_range(0, 11) == 0);
        pc_load_addr = ($urandom_range(0, 3) == 0) ? (24'hFFFFF0 | 24'($urandom_range(0, 15)))
                                                   : 24'($urandom);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 200) begin step(); n++; end
    if (n >= 200) chk({name, "_wait_valid_timeout"}, 32'(n), 32'd0);
  endtask

  int n;

  initial begin
    rst = 1'b1; pc_load = 1'b0; pc_load_addr = 24'h0; instr_ready = 1'b0;
    mem_fetch_done = 1'b0; mem_fetched_data = 32'h0;
    repeat (3) step();
    cmp_en = 1'b1;
    // reset values
    chk("rst_mem_address", {8'h0, mem_address}, 32'h0);
    chk("rst_start", {31'h0, mem_start_fetch}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    rst = 1'b0;

    // first fetch and byte order
    wait_valid("first");
    chk("first_instr", instr, 32'h00100093);
    chk("first_instr_pc", {8'h0, instr_pc}, 32'h0);
    chk("first_start_low", {31'h0, mem_start_fetch}, 32'h0);

    // backpressure: hold for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_instr", instr, 32'h00100093);
      chk("bp_instr_pc", {8'h0, instr_pc}, 32'h0);
      chk("bp_start", {31'h0, mem_start_fetch}, 32'h0);
    end

    // streaming with ready held high; one low start cycle between fetches
    instr_ready = 1'b1;
    step();
    chk("stream_start", {31'h0, mem_start_fetch}, 32'h1);
    chk("stream_addr", {8'h0, mem_address}, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      wait_valid("stream");
      chk("stream_instr_pc", {8'h0, instr_pc}, 32'(4 * k));
      chk("stream_gap_low", {31'h0, mem_start_fetch}, 32'h0);
      step();
      chk("stream_restart", {31'h0, mem_start_fetch}, 32'h1);
      chk("stream_next_addr", {8'h0, mem_address}, 32'(4 * (k + 1)));
    end

    // redirect mid-fetch with a colliding done
    pc_load = 1'b1; pc_load_addr = 24'h000123;
    mem_fetch_done = 1'b1; mem_fetched_data = 32'hDEADBEEF;
    step();
    pc_load = 1'b0;
    chk("redir_gap_start", {31'h0, mem_start_fetch}, 32'h0);
    chk("redir_no_valid", {31'h0, instr_valid}, 32'h0);
    chk("redir_addr_held", {8'h0, mem_address}, 32'h10);
    step();
    chk("redir_start", {31'h0, mem_start_fetch}, 32'h1);
    chk("redir_addr", {8'h0, mem_address}, 32'h120);

    // timeout and retry
    instr_ready = 1'b0;
    wait_valid("redir");
    chk("redir_instr_pc", {8'h0, instr_pc}, 32'h120);
    mem_lat = 0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("tmo_addr", {8'h0, mem_address}, 32'h124);
    n = 0;
    while (fetch_timeout !== 1'b1 && n < 60) begin step(); n++; end
    chk("tmo_latency", 32'(n), 32'(TMO));
    chk("tmo_start_low", {31'h0, mem_start_fetch}, 32'h0);
    mem_lat = 3;
    step();
    chk("tmo_pulse_once", {31'h0, fetch_timeout}, 32'h0);
    chk("tmo_retry_start", {31'h0, mem_start_fetch}, 32'h1);
    chk("tmo_retry_addr", {8'h0, mem_address}, 32'h124);

    // wrap past the top of the address space
    wait_valid("retry");
    chk("retry_instr_pc", {8'h0, instr_pc}, 32'h124);
    pc_load = 1'b1; pc_load_addr = 24'hFFFFFE;
    step();
    pc_load = 1'b0;
    chk("drop_valid", {31'h0, instr_valid}, 32'h0);
    chk("wrap_addr_top", {8'h0, mem_address}, 32'hFFFFFC);
    wait_valid("wrap");
    chk("wrap_instr_pc", {8'h0, instr_pc}, 32'hFFFFFC);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("wrap_addr_zero", {8'h0, mem_address}, 32'h0);
    chk("wrap_start", {31'h0, mem_start_fetch}, 32'h1);

    // asynchronous reset mid-fetch
    #1 rst = 1'b1;
    #1;
    chk("arst_start", {31'h0, mem_start_fetch}, 32'h0);
    chk("arst_addr", {8'h0, mem_address}, 32'h0);
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_instr_pc", {8'h0, instr_pc}, 32'h0);
    chk("arst_timeout", {31'h0, fetch_timeout}, 32'h0);
    step();
    rst = 1'b0;

    // randomized traffic
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    pc_load = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
